subtractor3_serial: RTL and testbench



---
 rtl/subtractor3_serial.sv | 109 ++++++++++
 tb/tb_subtractor3_serial.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/subtractor3_serial.sv
// Bit-serial unsigned subtractor: in1 - in2, one bit per clock, LSB first,
// with a start/done handshake and a held {borrow_out, difference} result.
module subtractor3_serial #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   diff
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-2:0] res_q, res_d;
    logic             bor_q, bor_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   diff_q, diff_d;
    logic             done_q, done_d;

    logic             bit_d;
    logic             bor_nx;

    // Operands shift right so the active bit is always at position 0;
    // cnt only tracks how many bits have been processed.
    always_comb begin
        bit_d  = a_q[0] ^ b_q[0] ^ bor_q;
        bor_nx = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bor_q);

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        bor_d   = bor_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = in1;
                    b_d     = in2;
                    bor_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = {bit_d, res_q[WIDTH-2:1]};
                bor_d = bor_nx;
                cnt_d = cnt_q + 1'b1;
                // res_q already holds bits 0..WIDTH-2; the top bit is bit_d.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    diff_d  = {bor_nx, bit_d, res_q};
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            bor_q   <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            bor_q   <= bor_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign diff = diff_q;

endmodule

// File: tb/tb_subtractor3_serial.sv
// Directed bench for subtractor3_serial: WIDTH=3 instance for handshake and
// corner tests, WIDTH=4 instance for the wider exhaustive sweep.
module tb_subtractor3_serial;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       start3;
    logic [2:0] in1_3, in2_3;
    logic       busy3, done3;
    logic [3:0] diff3;

    logic       start4;
    logic [3:0] in1_4, in2_4;
    logic       busy4, done4;
    logic [4:0] diff4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    subtractor3_serial #(.WIDTH(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start3),
        .in1   (in1_3),
        .in2   (in2_3),
        .busy  (busy3),
        .done  (done3),
        .diff  (diff3)
    );

    subtractor3_serial #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .in1   (in1_4),
        .in2   (in2_4),
        .busy  (busy4),
        .done  (done4),
        .diff  (diff4)
    );

    // Issues one operation and observes a fixed window of cycles after the
    // accept edge; lat is the number of edges from accept to done (-1 if none).
    task automatic do_op3(input logic [2:0] x, input logic [2:0] y,
                          output int lat, output logic [3:0] d,
                          output int busy_n, output int done_n);
        lat = -1; d = 'x; busy_n = 0; done_n = 0;
        @(negedge clk);
        in1_3 = x; in2_3 = y; start3 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            start3 = 1'b0;
            if (busy3 === 1'b1) busy_n++;
            if (done3 === 1'b1) begin
                done_n++;
                if (lat < 0) begin
                    lat = k;
                    d   = diff3;
                end
            end
        end
    endtask

    task automatic do_op4(input logic [3:0] x, input logic [3:0] y,
                          output int lat, output logic [4:0] d,
                          output int busy_n, output int done_n);
        lat = -1; d = 'x; busy_n = 0; done_n = 0;
        @(negedge clk);
        in1_4 = x; in2_4 = y; start4 = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            start4 = 1'b0;
            if (busy4 === 1'b1) busy_n++;
            if (done4 === 1'b1) begin
                done_n++;
                if (lat < 0) begin
                    lat = k;
                    d   = diff4;
                end
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start3 = 1'b0; in1_3 = '0; in2_3 = '0;
        start4 = 1'b0; in1_4 = '0; in2_4 = '0;
        #12;
        checks++;
        if (busy3 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy3); end
        checks++;
        if (done3 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done3); end
        checks++;
        if (diff3 !== 4'b0000) begin errors++; $display("FAIL reset_diff: got %b expected 0000", diff3); end
        checks++;
        if (diff4 !== 5'b00000) begin errors++; $display("FAIL reset_diff4: got %b expected 00000", diff4); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int lat, bn, dn;
        logic [3:0] d;
        do_op3(3'd5, 3'd3, lat, d, bn, dn);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL basic_latency: got %0d expected 3", lat); end
        checks++;
        if (d !== 4'b0010) begin errors++; $display("FAIL basic_diff: got %b expected 0010", d); end
        checks++;
        if (bn !== 4) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 4", bn); end
        checks++;
        if (dn !== 1) begin errors++; $display("FAIL basic_done_cycles: got %0d expected 1", dn); end
        checks++;
        if (diff3 !== 4'b0010) begin errors++; $display("FAIL basic_diff_held: got %b expected 0010", diff3); end
    endtask

    task automatic test_borrow;
        int lat, bn, dn;
        logic [3:0] d;
        do_op3(3'd3, 3'd5, lat, d, bn, dn);
        checks++;
        if (d !== 4'b1110) begin errors++; $display("FAIL borrow_diff: got %b expected 1110", d); end
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL borrow_latency: got %0d expected 3", lat); end
    endtask

    task automatic test_corners;
        logic [2:0] ca [4] = '{3'd0, 3'd7, 3'd0, 3'd7};
        logic [2:0] cb [4] = '{3'd0, 3'd7, 3'd7, 3'd0};
        logic [3:0] ce [4] = '{4'b0000, 4'b0000, 4'b1001, 4'b0111};
        int lat, bn, dn;
        logic [3:0] d;
        for (int i = 0; i < 4; i++) begin
            do_op3(ca[i], cb[i], lat, d, bn, dn);
            checks++;
            if (d !== ce[i]) begin
                errors++;
                $display("FAIL corner_diff %0d-%0d: got %b expected %b", ca[i], cb[i], d, ce[i]);
            end
            checks++;
            if (dn !== 1) begin
                errors++;
                $display("FAIL corner_done_cycles %0d-%0d: got %0d expected 1", ca[i], cb[i], dn);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [2:0] opa [20];
        logic [2:0] opb [20];
        logic [3:0] last;
        logic       seen;
        logic       exp_done, exp_busy;
        int         src;
        seen = 1'b0;
        last = '0;
        @(negedge clk);
        for (int cyc = 0; cyc < 20; cyc++) begin
            opa[cyc] = 3'((cyc * 3 + 1) % 8);
            opb[cyc] = 3'((cyc * 5 + 2) % 8);
            in1_3 = opa[cyc]; in2_3 = opb[cyc]; start3 = 1'b1;
            @(negedge clk);
            exp_done = ((cyc % 5) == 3);
            exp_busy = ((cyc % 5) != 4);
            if (exp_done) begin
                src = cyc - 3;
                last[3]   = (opa[src] < opb[src]);
                last[2:0] = 3'((int'(opa[src]) - int'(opb[src])) & 7);
                seen = 1'b1;
            end
            checks++;
            if (done3 !== exp_done) begin
                errors++;
                $display("FAIL b2b_done cyc %0d: got %b expected %b", cyc, done3, exp_done);
            end
            checks++;
            if (busy3 !== exp_busy) begin
                errors++;
                $display("FAIL b2b_busy cyc %0d: got %b expected %b", cyc, busy3, exp_busy);
            end
            if (seen) begin
                checks++;
                if (diff3 !== last) begin
                    errors++;
                    $display("FAIL b2b_diff cyc %0d: got %b expected %b", cyc, diff3, last);
                end
            end
        end
        start3 = 1'b0;
    endtask

    task automatic test_reset_mid_shift;
        int lat, bn, dn;
        logic [3:0] d;
        int         stray;
        @(negedge clk);
        in1_3 = 3'd5; in2_3 = 3'd3; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        @(negedge clk);
        checks++;
        if (busy3 !== 1'b1) begin errors++; $display("FAIL midrst_pre_busy: got %b expected 1", busy3); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy3 !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy3); end
        checks++;
        if (done3 !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", done3); end
        checks++;
        if (diff3 !== 4'b0000) begin errors++; $display("FAIL midrst_diff: got %b expected 0000", diff3); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (done3 !== 1'b0) stray++;
        end
        checks++;
        if (stray !== 0) begin errors++; $display("FAIL midrst_stray_done: got %0d expected 0", stray); end
        do_op3(3'd6, 3'd1, lat, d, bn, dn);
        checks++;
        if (d !== 4'b0101) begin errors++; $display("FAIL midrst_after_diff: got %b expected 0101", d); end
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL midrst_after_latency: got %0d expected 3", lat); end
    endtask

    task automatic test_sweep3;
        int lat, bn, dn;
        logic [3:0] d, e;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                e[3]   = (i < j);
                e[2:0] = 3'((i - j) & 7);
                do_op3(3'(i), 3'(j), lat, d, bn, dn);
                checks++;
                if (d !== e || lat !== 3) begin
                    errors++;
                    $display("FAIL sweep3 %0d-%0d: got %b lat %0d expected %b lat 3", i, j, d, lat, e);
                end
            end
        end
    endtask

    task automatic test_sweep4;
        int lat, bn, dn;
        logic [4:0] d, e;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                e[4]   = (i < j);
                e[3:0] = 4'((i - j) & 15);
                do_op4(4'(i), 4'(j), lat, d, bn, dn);
                checks++;
                if (d !== e || lat !== 4 || bn !== 5) begin
                    errors++;
                    $display("FAIL sweep4 %0d-%0d: got %b lat %0d busy %0d expected %b lat 4 busy 5",
                             i, j, d, lat, bn, e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_corners();
        test_back_to_back();
        test_reset_mid_shift();
        test_sweep3();
        test_sweep4();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
